// File: rtl/lut_stream_rom_if.sv
// Request, sweep-control, output-stream and table-write signals of lut_stream_rom.
// The slave modport is the ROM's view; master is the driver/consumer view.
interface lut_stream_rom_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              sweep_start;
    logic [ADDR_W-1:0] sweep_base;
    logic [ADDR_W:0]   sweep_len;
    logic              busy;
    logic              sweep_done;
    logic [DATA_W-1:0] q;
    logic [ADDR_W-1:0] q_addr;
    logic              q_valid;
    logic              q_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output req_valid, req_addr, sweep_start, sweep_base, sweep_len,
               q_ready, wr_en, wr_addr, wr_data,
        input  req_ready, busy, sweep_done, q, q_addr, q_valid
    );

    modport slave (
        input  req_valid, req_addr, sweep_start, sweep_base, sweep_len,
               q_ready, wr_en, wr_addr, wr_data,
        output req_ready, busy, sweep_done, q, q_addr, q_valid
    );
endinterface

// File: rtl/lut_stream_rom.sv
// Lookup table with a registered valid/ready output, fed by single lookups or a wrapping sweep.
// Define LUT_WRITE_EN to make the table writable (read-before-write); otherwise it is a constant ROM.
module lut_stream_rom #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    lut_stream_rom_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, SWEEP} state_t;

    function automatic logic [DATA_W-1:0] default_entry(input int idx);
        logic [31:0] v;
        case (idx)
            0:       v = 32'd4658;
            1:       v = 32'd44768;
            2:       v = 32'd10196;
            3:       v = 32'd23054;
            4:       v = 32'd8294;
            5:       v = 32'd25806;
            6:       v = 32'd50470;
            7:       v = 32'd12057;
            default: v = 32'd0;
        endcase
        return DATA_W'(v);
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [ADDR_W-1:0] q_addr_q, q_addr_d;
    logic              q_valid_q, q_valid_d;
    logic              q_last_q, q_last_d;
    logic              done_q, done_d;

    logic              slot_free;
    logic              beat;
    logic              beat_last;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] init_w [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_init
            assign init_w[gi] = default_entry(gi);
        end
    endgenerate

`ifdef LUT_WRITE_EN
    logic [DATA_W-1:0] table_q [DEPTH];

    // Reads see the pre-write contents, so a same-cycle write shows up on the next beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= init_w[i];
            end
        end else if (bus.wr_en) begin
            table_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign rd_data = table_q[rd_addr];
`else
    logic unused_wr;
    assign unused_wr = ^{bus.wr_en, bus.wr_addr, bus.wr_data};
    assign rd_data   = init_w[rd_addr];
`endif

    assign slot_free = !q_valid_q || bus.q_ready;
    assign rd_addr   = (state_q == SWEEP) ? ptr_q : bus.req_addr;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        q_d       = q_q;
        q_addr_d  = q_addr_q;
        q_valid_d = q_valid_q;
        q_last_d  = q_last_q;
        beat      = 1'b0;
        beat_last = 1'b0;
        // Completion is signalled once the consumer takes the final sweep beat.
        done_d    = q_valid_q && bus.q_ready && q_last_q;

        unique case (state_q)
            IDLE: begin
                if (bus.sweep_start) begin
                    if (bus.sweep_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SWEEP;
                        ptr_d   = bus.sweep_base;
                        rem_d   = bus.sweep_len;
                    end
                end else if (bus.req_valid && slot_free) begin
                    beat = 1'b1;
                end
            end
            SWEEP: begin
                if (slot_free) begin
                    beat  = 1'b1;
                    ptr_d = ptr_q + ADDR_W'(1);
                    rem_d = rem_q - (ADDR_W + 1)'(1);
                    if (rem_q == (ADDR_W + 1)'(1)) begin
                        beat_last = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (beat) begin
            q_d       = rd_data;
            q_addr_d  = rd_addr;
            q_valid_d = 1'b1;
            q_last_d  = beat_last;
        end else if (q_valid_q && bus.q_ready) begin
            q_valid_d = 1'b0;
            q_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            q_addr_q  <= '0;
            q_valid_q <= 1'b0;
            q_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            q_q       <= q_d;
            q_addr_q  <= q_addr_d;
            q_valid_q <= q_valid_d;
            q_last_q  <= q_last_d;
            done_q    <= done_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE) && !bus.sweep_start && slot_free;
    assign bus.busy       = (state_q == SWEEP);
    assign bus.sweep_done = done_q;
    assign bus.q          = q_q;
    assign bus.q_addr     = q_addr_q;
    assign bus.q_valid    = q_valid_q;
endmodule

// File: tb/tb_lut_stream_rom.sv
// Self-checking bench for lut_stream_rom: directed scenarios plus random traffic,
// all compared every cycle against a transaction-level model of the table and output slot.
module tb_lut_stream_rom;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lut_stream_rom_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lut_stream_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int def_tbl [DEPTH] = '{4658, 44768, 10196, 23054, 8294, 25806, 50470, 12057};

    // Model state: table contents, sweep progress and the single output slot.
    int m_tbl [DEPTH];
    bit m_busy;
    int m_ptr, m_rem;
    bit m_qv, m_last, m_done;
    int m_q, m_qa;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = def_tbl[i];
        m_busy = 0; m_ptr = 0; m_rem = 0;
        m_qv = 0; m_last = 0; m_done = 0; m_q = 0; m_qa = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit sf, beat, blast, nd;
        int baddr;
        if (reset) begin
            model_reset();
            return;
        end
        sf = !m_qv || bus.q_ready;
        beat = 0; blast = 0; baddr = 0;
        nd = m_qv && bus.q_ready && m_last;
        if (!m_busy) begin
            if (bus.sweep_start) begin
                if (bus.sweep_len == 0) nd = 1;
                else begin
                    m_busy = 1;
                    m_ptr  = int'(bus.sweep_base);
                    m_rem  = int'(bus.sweep_len);
                end
            end else if (bus.req_valid && sf) begin
                beat = 1;
                baddr = int'(bus.req_addr);
            end
        end else if (sf) begin
            beat  = 1;
            baddr = m_ptr;
            blast = (m_rem == 1);
            m_ptr = (m_ptr + 1) % DEPTH;
            m_rem = m_rem - 1;
            if (m_rem == 0) m_busy = 0;
        end
        if (beat) begin
            m_q = m_tbl[baddr]; m_qa = baddr; m_qv = 1; m_last = blast;
        end else if (m_qv && bus.q_ready) begin
            m_qv = 0; m_last = 0;
        end
`ifdef LUT_WRITE_EN
        if (bus.wr_en) m_tbl[bus.wr_addr] = int'(bus.wr_data);
`endif
        m_done = nd;
    endtask

    // One clock: check req_ready, step model, then compare registered outputs at the falling edge.
    task automatic cycle();
        bit sf;
        #1;
        sf = !m_qv || bus.q_ready;
        chk("req_ready", longint'(bus.req_ready), longint'(!m_busy && !bus.sweep_start && sf));
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("q_valid", longint'(bus.q_valid), longint'(m_qv));
        chk("busy", longint'(bus.busy), longint'(m_busy));
        chk("sweep_done", longint'(bus.sweep_done), longint'(m_done));
        if (m_qv) begin
            chk("q", longint'(bus.q), longint'(m_q));
            chk("q_addr", longint'(bus.q_addr), longint'(m_qa));
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid = 0; bus.req_addr = '0; bus.sweep_start = 0; bus.sweep_base = '0;
        bus.sweep_len = '0; bus.q_ready = 1; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    endtask

    initial begin
        int busy_cnt, done_cnt, nb;
        int t3_addr [4] = '{6, 7, 0, 1};
        int t3_data [4] = '{50470, 12057, 4658, 44768};

        idle_inputs();
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("reset q", longint'(bus.q), 0);
        chk("reset q_addr", longint'(bus.q_addr), 0);
        chk("reset q_valid", longint'(bus.q_valid), 0);
        chk("reset busy", longint'(bus.busy), 0);
        chk("reset sweep_done", longint'(bus.sweep_done), 0);
        reset = 0;

        // T1: back-to-back lookups of every entry.
        for (int i = 0; i < DEPTH; i++) begin
            bus.req_valid = 1; bus.req_addr = ADDR_W'(i); bus.q_ready = 1;
            cycle();
            chk("T1 q", longint'(bus.q), longint'(def_tbl[i]));
            chk("T1 q_addr", longint'(bus.q_addr), longint'(i));
        end

        // T2: lookup of addr 6 held by a stalled consumer.
        bus.req_valid = 0; cycle();
        bus.req_valid = 1; bus.req_addr = 3'd6; bus.q_ready = 0;
        cycle();
        bus.req_addr = 3'd2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("T2 q held", longint'(bus.q), 50470);
            chk("T2 q_addr held", longint'(bus.q_addr), 6);
            chk("T2 req_ready", longint'(bus.req_ready), 0);
        end
        bus.req_valid = 0; bus.q_ready = 1;
        cycle();
        chk("T2 released", longint'(bus.q_valid), 0);

        // T3: wrapping sweep of four entries starting at 6.
        bus.sweep_start = 1; bus.sweep_base = 3'd6; bus.sweep_len = 4'd4;
        busy_cnt = 0; done_cnt = 0; nb = 0;
        cycle();
        busy_cnt += int'(bus.busy);
        bus.sweep_start = 0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.sweep_done);
            if (bus.q_valid) begin
                if (nb < 4) begin
                    chk("T3 q_addr", longint'(bus.q_addr), longint'(t3_addr[nb]));
                    chk("T3 q", longint'(bus.q), longint'(t3_data[nb]));
                end
                nb++;
            end
        end
        chk("T3 beats", longint'(nb), 4);
        chk("T3 busy cycles", longint'(busy_cnt), 4);
        chk("T3 done pulses", longint'(done_cnt), 1);

        // T4: empty sweep beats a concurrent request.
        bus.sweep_start = 1; bus.sweep_len = '0; bus.req_valid = 1; bus.req_addr = 3'd1;
        cycle();
        chk("T4 no q_valid", longint'(bus.q_valid), 0);
        chk("T4 sweep_done", longint'(bus.sweep_done), 1);
        bus.sweep_start = 0; bus.req_valid = 0;
        cycle();
        chk("T4 done single", longint'(bus.sweep_done), 0);

`ifdef LUT_WRITE_EN
        // T5: read-before-write, then reset restores the default.
        bus.req_valid = 1; bus.req_addr = 3'd3;
        bus.wr_en = 1; bus.wr_addr = 3'd3; bus.wr_data = 16'h1234;
        cycle();
        chk("T5 old data", longint'(bus.q), 23054);
        bus.wr_en = 0;
        cycle();
        chk("T5 new data", longint'(bus.q), 16'h1234);
        bus.req_valid = 0; reset = 1;
        cycle();
        reset = 0; bus.req_valid = 1;
        cycle();
        chk("T5 reloaded", longint'(bus.q), 23054);
        bus.req_valid = 0;
`endif

        // T6: reset during the second beat of an 8-entry sweep.
        bus.sweep_start = 1; bus.sweep_base = '0; bus.sweep_len = 4'd8;
        cycle();
        bus.sweep_start = 0;
        cycle();
        reset = 1;
        cycle();
        chk("T6 busy", longint'(bus.busy), 0);
        chk("T6 q_valid", longint'(bus.q_valid), 0);
        chk("T6 sweep_done", longint'(bus.sweep_done), 0);
        reset = 0;
        cycle();
        chk("T6 no late done", longint'(bus.sweep_done), 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(199) == 0);
            bus.sweep_start = ($urandom_range(9) == 0);
            bus.sweep_base  = ADDR_W'($urandom_range(DEPTH - 1));
            bus.sweep_len   = (ADDR_W + 1)'($urandom_range(15));
            bus.req_valid   = 1'($urandom_range(1));
            bus.req_addr    = ADDR_W'($urandom_range(DEPTH - 1));
            bus.q_ready     = ($urandom_range(3) != 0);
            bus.wr_en       = ($urandom_range(3) == 0);
            bus.wr_addr     = ADDR_W'($urandom_range(DEPTH - 1));
            bus.wr_data     = DATA_W'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
